// File: rtl/proc_control_fsm.sv
// Five-state sequencing controller for the cs147sec05 data path. Each instruction
// takes FETCH->DECODE->EXE->MEM->WB, and CTRL is registered for the state being entered.
module proc_control_fsm (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTRUCTION,
  input  logic        ZERO,
  output logic [31:0] CTRL,
  output logic [2:0]  STATE
);

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_MUL = 5'd3;
  localparam logic [4:0] ALU_SHR = 5'd4;
  localparam logic [4:0] ALU_SHL = 5'd5;
  localparam logic [4:0] ALU_AND = 5'd6;
  localparam logic [4:0] ALU_OR  = 5'd7;
  localparam logic [4:0] ALU_NOR = 5'd8;
  localparam logic [4:0] ALU_SLT = 5'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_q, state_next;
  logic [31:0] ctrl_q, ctrl_next;
  logic [31:0] instr_q;

  logic [5:0] op, fn;
  logic [4:0] alu_code;
  logic       op2_r2, op2_sel1, op2_shamt, imm_sext, op1_sp;
  logic       r_alu, jr, i_write, is_jal, is_push, is_pop, is_lw, is_sw, is_lui;
  logic       is_beq, is_bne, is_jmp;

  assign op = instr_q[31:26];
  assign fn = instr_q[5:0];

  // Instruction classification from the latched word; unknown codes leave every flag clear.
  always_comb begin
    alu_code  = 5'd0;
    op2_r2    = 1'b0;
    op2_sel1  = 1'b0;
    op2_shamt = 1'b0;
    imm_sext  = 1'b0;
    op1_sp    = 1'b0;
    r_alu     = 1'b0;
    jr        = 1'b0;
    i_write   = 1'b0;
    is_jal    = 1'b0;
    is_push   = 1'b0;
    is_pop    = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_lui    = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jmp    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          6'h20: begin alu_code = ALU_ADD; op2_r2 = 1'b1; r_alu = 1'b1; end
          6'h22: begin alu_code = ALU_SUB; op2_r2 = 1'b1; r_alu = 1'b1; end
          6'h2c: begin alu_code = ALU_MUL; op2_r2 = 1'b1; r_alu = 1'b1; end
          6'h24: begin alu_code = ALU_AND; op2_r2 = 1'b1; r_alu = 1'b1; end
          6'h25: begin alu_code = ALU_OR;  op2_r2 = 1'b1; r_alu = 1'b1; end
          6'h27: begin alu_code = ALU_NOR; op2_r2 = 1'b1; r_alu = 1'b1; end
          6'h2a: begin alu_code = ALU_SLT; op2_r2 = 1'b1; r_alu = 1'b1; end
          6'h01: begin alu_code = ALU_SHL; op2_sel1 = 1'b1; op2_shamt = 1'b1; r_alu = 1'b1; end
          6'h02: begin alu_code = ALU_SHR; op2_sel1 = 1'b1; op2_shamt = 1'b1; r_alu = 1'b1; end
          6'h08: jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin alu_code = ALU_ADD; imm_sext = 1'b1; i_write = 1'b1; end
      OP_MULI: begin alu_code = ALU_MUL; imm_sext = 1'b1; i_write = 1'b1; end
      OP_SLTI: begin alu_code = ALU_SLT; imm_sext = 1'b1; i_write = 1'b1; end
      OP_ANDI: begin alu_code = ALU_AND; i_write = 1'b1; end
      OP_ORI:  begin alu_code = ALU_OR;  i_write = 1'b1; end
      OP_LW:   begin alu_code = ALU_ADD; imm_sext = 1'b1; i_write = 1'b1; is_lw = 1'b1; end
      OP_SW:   begin alu_code = ALU_ADD; imm_sext = 1'b1; is_sw = 1'b1; end
      OP_LUI:  begin i_write = 1'b1; is_lui = 1'b1; end
      OP_BEQ:  begin alu_code = ALU_SUB; op2_r2 = 1'b1; is_beq = 1'b1; end
      OP_BNE:  begin alu_code = ALU_SUB; op2_r2 = 1'b1; is_bne = 1'b1; end
      OP_PUSH: begin alu_code = ALU_SUB; op1_sp = 1'b1; op2_sel1 = 1'b1; is_push = 1'b1; end
      OP_POP:  begin alu_code = ALU_ADD; op1_sp = 1'b1; op2_sel1 = 1'b1; is_pop = 1'b1; end
      OP_JMP:  is_jmp = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      default: ;
    endcase
  end

  // ctrl_next is the word for the state being entered on the coming edge.
  always_comb begin
    state_next = S_FETCH;
    ctrl_next  = 32'h0;
    case (state_q)
      S_FETCH: begin
        state_next    = S_DECODE;
        ctrl_next[30] = 1'b1;
        ctrl_next[7]  = 1'b1;
        ctrl_next[6]  = (INSTRUCTION[31:26] == OP_PUSH);
      end
      S_DECODE: begin
        state_next        = S_EXE;
        ctrl_next[25:21]  = alu_code;
        ctrl_next[20]     = op2_r2;
        ctrl_next[19]     = op2_sel1;
        ctrl_next[18]     = imm_sext;
        ctrl_next[17]     = op2_shamt;
        ctrl_next[16]     = op1_sp;
      end
      S_EXE: begin
        state_next       = S_MEM;
        ctrl_next[25:21] = ctrl_q[25:21];
        ctrl_next[4]     = is_lw | is_pop;
        ctrl_next[5]     = is_sw | is_push;
        ctrl_next[26]    = is_push;
        ctrl_next[29]    = is_push;
      end
      S_MEM: begin
        state_next       = S_WB;
        ctrl_next[25:21] = ctrl_q[25:21];
        ctrl_next[0]     = 1'b1;
        ctrl_next[3]     = ~(is_jmp | is_jal);
        ctrl_next[2]     = (is_beq & ZERO) | (is_bne & ~ZERO);
        ctrl_next[1]     = ~jr;
        ctrl_next[8]     = r_alu | i_write | is_jal | is_pop;
        ctrl_next[11]    = r_alu | i_write;
        ctrl_next[9]     = i_write;
        ctrl_next[10]    = is_jal;
        ctrl_next[14]    = r_alu | i_write | is_pop;
        ctrl_next[13]    = is_lui;
        ctrl_next[12]    = is_lw | is_pop;
        ctrl_next[15]    = is_push | is_pop;
      end
      S_WB: begin
        state_next    = S_FETCH;
        ctrl_next[31] = 1'b1;
        ctrl_next[4]  = 1'b1;
      end
      default: begin
        state_next    = S_FETCH;
        ctrl_next[31] = 1'b1;
        ctrl_next[4]  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      ctrl_q  <= 32'h0;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_next;
      ctrl_q  <= ctrl_next;
      if (state_q == S_FETCH) instr_q <= INSTRUCTION;
    end
  end

  assign CTRL  = ctrl_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: walks instructions through all five states
// and compares STATE/CTRL against hand-computed words.
module tb_proc_control_fsm;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] INSTRUCTION = 32'h0;
  logic        ZERO = 1'b0;
  logic [31:0] CTRL;
  logic [2:0]  STATE;

  int total = 0;
  int bad   = 0;

  proc_control_fsm dut (
    .CLK(CLK),
    .RST(RST),
    .INSTRUCTION(INSTRUCTION),
    .ZERO(ZERO),
    .CTRL(CTRL),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH; checks DECODE, EXE, MEM, WB and the return to FETCH.
  task automatic run_instr(input string name, input logic [31:0] instr, input logic z,
                           input logic [31:0] e_dec, input logic [31:0] e_exe,
                           input logic [31:0] e_mem, input logic [31:0] e_wb);
    INSTRUCTION = instr;
    ZERO = z;
    tick();
    check({name, "_dec_state"}, {29'd0, STATE}, 32'd1);
    check({name, "_dec_ctrl"}, CTRL, e_dec);
    INSTRUCTION = 32'hFFFF_FFFF;
    tick();
    check({name, "_exe_state"}, {29'd0, STATE}, 32'd2);
    check({name, "_exe_ctrl"}, CTRL, e_exe);
    tick();
    check({name, "_mem_state"}, {29'd0, STATE}, 32'd3);
    check({name, "_mem_ctrl"}, CTRL, e_mem);
    tick();
    check({name, "_wb_state"}, {29'd0, STATE}, 32'd4);
    check({name, "_wb_ctrl"}, CTRL, e_wb);
    tick();
    check({name, "_fetch_state"}, {29'd0, STATE}, 32'd0);
    check({name, "_fetch_ctrl"}, CTRL, 32'h8000_0010);
  endtask

  initial begin
    RST = 1'b1;
    tick();
    tick();
    check("rst_state", {29'd0, STATE}, 32'd0);
    check("rst_ctrl", CTRL, 32'h0);
    RST = 1'b0;

    run_instr("add",  32'h0022_1820, 1'b0, 32'h4000_0080, 32'h0030_0000, 32'h0020_0000, 32'h0020_490B);
    run_instr("beq_t", 32'h1022_0004, 1'b1, 32'h4000_0080, 32'h0050_0000, 32'h0040_0000, 32'h0040_000F);
    run_instr("beq_n", 32'h1022_0004, 1'b0, 32'h4000_0080, 32'h0050_0000, 32'h0040_0000, 32'h0040_000B);
    run_instr("push", 32'h6C00_0000, 1'b0, 32'h4000_00C0, 32'h0049_0000, 32'h2440_0020, 32'h0040_800B);
    run_instr("jal",  32'h0C00_0010, 1'b0, 32'h4000_0080, 32'h0000_0000, 32'h0000_0000, 32'h0000_0503);
    run_instr("lw",   32'h8C22_0004, 1'b0, 32'h4000_0080, 32'h0024_0000, 32'h0020_0010, 32'h0020_5B0B);
    run_instr("nop",  32'hFC00_0000, 1'b1, 32'h4000_0080, 32'h0000_0000, 32'h0000_0000, 32'h0000_000B);

    // Reset during EXE aborts the jal: no WB word may follow.
    INSTRUCTION = 32'h0C00_0010;
    tick();
    tick();
    check("abort_exe_state", {29'd0, STATE}, 32'd2);
    RST = 1'b1;
    tick();
    check("abort_state", {29'd0, STATE}, 32'd0);
    check("abort_ctrl", CTRL, 32'h0);
    RST = 1'b0;
    INSTRUCTION = 32'h0000_0000;
    tick();
    check("post_abort_state", {29'd0, STATE}, 32'd1);
    check("post_abort_ctrl", CTRL, 32'h4000_0080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
